// File: rtl/dotfetch.sv
// Request front end for the dotcal bicubic stage: fetches four border-clamped
// taps of one image row from a synchronous ROM, starts dotcal and returns its result.
module dotfetch #(
  parameter int unsigned IMG_W  = 100,
  parameter int unsigned IMG_H  = 100,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [6:0]        src_x,
  input  logic [6:0]        src_y,
  input  logic [5:0]        frac_mul,
  input  logic [5:0]        frac_div,
  output logic              ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic              dc_start,
  output logic [22:0]       dc_dot0,
  output logic [22:0]       dc_dot1,
  output logic [22:0]       dc_dot2,
  output logic [22:0]       dc_dot3,
  output logic [5:0]        dc_mul,
  output logic [5:0]        dc_div,
  input  logic              dc_finish,
  input  logic [7:0]        dc_result,
  output logic [7:0]        pix_out,
  output logic              pix_valid
);

  localparam logic signed [8:0] MAX_COL = 9'(IMG_W - 1);

  if (IMG_W < 2 || IMG_W > 127 || (IMG_W * IMG_H) > (1 << ADDR_W)) begin : g_bad_geometry
    $error("dotfetch: image geometry does not fit the column or address range");
  end

  typedef enum logic [2:0] {IDLE, READ, LAST, START, WAIT, DONE} state_t;

  state_t              state_q;
  logic [1:0]          tap_q;
  logic [6:0]          x_q;
  logic [6:0]          y_q;
  logic                ready_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                dc_start_q;
  logic [7:0]          dot_q [4];
  logic [5:0]          mul_q;
  logic [5:0]          div_q;
  logic [7:0]          pix_q;
  logic                pix_valid_q;

  // Row address of tap k, column x-1+k clamped into the image.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [6:0] x, input logic [6:0] y,
                                                 input logic [1:0] k);
    logic signed [8:0] col;
    col = $signed({2'b00, x}) + $signed({7'b0, k}) - 9'sd1;
    if (col < 9'sd0) begin
      col = 9'sd0;
    end else if (col > MAX_COL) begin
      col = MAX_COL;
    end
    return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'($unsigned(col));
  endfunction

  // ROM data lags the address by one cycle, so tap k-1 lands while tap k is addressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= 2'd0;
      x_q         <= 7'd0;
      y_q         <= 7'd0;
      ready_q     <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      dc_start_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dot_q[i] <= 8'd0;
      end
      mul_q       <= 6'd0;
      div_q       <= 6'd1;
      pix_q       <= 8'd0;
      pix_valid_q <= 1'b0;
    end else begin
      dc_start_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            x_q        <= src_x;
            y_q        <= src_y;
            if (frac_div == 6'd0) begin
              mul_q <= 6'd0;
              div_q <= 6'd1;
            end else if (frac_mul > frac_div) begin
              mul_q <= frac_div;
              div_q <= frac_div;
            end else begin
              mul_q <= frac_mul;
              div_q <= frac_div;
            end
            tap_q      <= 2'd0;
            ready_q    <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= tap_addr(src_x, src_y, 2'd0);
            state_q    <= READ;
          end
        end
        READ: begin
          if (tap_q != 2'd0) begin
            dot_q[tap_q - 2'd1] <= mem_q;
          end
          if (tap_q == 2'd3) begin
            mem_rd_q <= 1'b0;
            state_q  <= LAST;
          end else begin
            mem_addr_q <= tap_addr(x_q, y_q, tap_q + 2'd1);
            tap_q      <= tap_q + 2'd1;
          end
        end
        LAST: begin
          dot_q[3]   <= mem_q;
          dc_start_q <= 1'b1;
          state_q    <= START;
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (dc_finish) begin
            pix_q       <= dc_result;
            pix_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign dc_start  = dc_start_q;
  assign dc_dot0   = {15'b0, dot_q[0]};
  assign dc_dot1   = {15'b0, dot_q[1]};
  assign dc_dot2   = {15'b0, dot_q[2]};
  assign dc_dot3   = {15'b0, dot_q[3]};
  assign dc_mul    = mul_q;
  assign dc_div    = div_q;
  assign pix_out   = pix_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_dotfetch.sv
// Bench for dotfetch: ROM and dotcal models, a scoreboard of expected reads,
// dotcal starts and results, and a vector table plus corner-case sequences.
module tb_dotfetch;
  localparam int unsigned IMG_W  = 100;
  localparam int unsigned IMG_H  = 100;
  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [6:0]        src_x, src_y;
  logic [5:0]        frac_mul, frac_div;
  logic              ready, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_q;
  logic              dc_start;
  logic [22:0]       dc_dot0, dc_dot1, dc_dot2, dc_dot3;
  logic [5:0]        dc_mul, dc_div;
  logic              dc_finish;
  logic [7:0]        dc_result;
  logic [7:0]        pix_out;
  logic              pix_valid;

  always #5 clk = ~clk;

  dotfetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .go(go), .src_x(src_x), .src_y(src_y),
    .frac_mul(frac_mul), .frac_div(frac_div), .ready(ready), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_q(mem_q), .dc_start(dc_start),
    .dc_dot0(dc_dot0), .dc_dot1(dc_dot1), .dc_dot2(dc_dot2), .dc_dot3(dc_dot3),
    .dc_mul(dc_mul), .dc_div(dc_div), .dc_finish(dc_finish), .dc_result(dc_result),
    .pix_out(pix_out), .pix_valid(pix_valid)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image content: row 3 holds its own column index.
  function automatic logic [7:0] romv(input int a);
    return 8'((a % int'(IMG_W)) + 2 * (a / int'(IMG_W)) - 6);
  endfunction

  always @(posedge clk) if (mem_rd) mem_q <= romv(int'(mem_addr));

  // dotcal model: finish six cycles after the start pulse.
  int         dcnt;
  logic       model_fin;
  logic       force_fin;
  logic [7:0] res_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt      <= 0;
      model_fin <= 1'b0;
    end else begin
      model_fin <= 1'b0;
      if (dc_start) begin
        dcnt <= 5;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) model_fin <= 1'b1;
      end
    end
  end

  assign dc_finish = model_fin | force_fin;
  assign dc_result = res_val;

  typedef struct packed {
    logic [6:0] x, y;
    logic [5:0] mul, div;
    logic [7:0] res;
    logic [5:0] emul, ediv;
    logic [6:0] c0, c1, c2, c3;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } rd_t;

  typedef struct packed {
    logic [91:0] dots;
    logic [5:0]  mul, div;
    logic [7:0]  res;
    int          cyc;
  } tx_t;

  rd_t rd_q[$];
  tx_t tx_q[$];
  tx_t px_q[$];
  rd_t mr;
  tx_t mt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: reads, start pulses and result strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL extra_mem_rd: got addr %0d at cycle %0d, expected no read", mem_addr, cyc);
        end else begin
          mr = rd_q.pop_front();
          if (mem_addr !== mr.addr || cyc != mr.cyc) begin
            failures++;
            $display("FAIL mem_addr: got %0d at cycle %0d expected %0d at cycle %0d",
                     mem_addr, cyc, mr.addr, mr.cyc);
          end
        end
      end
      if (dc_start) begin
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL extra_dc_start: got start at cycle %0d, expected none", cyc);
        end else begin
          mt = tx_q.pop_front();
          if ({dc_dot3, dc_dot2, dc_dot1, dc_dot0} !== mt.dots || dc_mul !== mt.mul ||
              dc_div !== mt.div || cyc != mt.cyc) begin
            failures++;
            $display("FAIL dc_start: got dots %h mul %0d div %0d cycle %0d expected dots %h mul %0d div %0d cycle %0d",
                     {dc_dot3, dc_dot2, dc_dot1, dc_dot0}, dc_mul, dc_div, cyc,
                     mt.dots, mt.mul, mt.div, mt.cyc);
          end
          mt.cyc = mt.cyc + 7;
          px_q.push_back(mt);
        end
      end
      if (pix_valid) begin
        checks++;
        if (px_q.size() == 0) begin
          failures++;
          $display("FAIL extra_pix_valid: got pix_valid at cycle %0d, expected none", cyc);
        end else begin
          mt = px_q.pop_front();
          if (pix_out !== mt.res || cyc != mt.cyc) begin
            failures++;
            $display("FAIL pix_out: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                     pix_out, cyc, mt.res, mt.cyc);
          end
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    int n;
    int go_cyc;
    logic [6:0] c [4];
    logic [91:0] dots;
    rd_t r;
    tx_t t;
    @(negedge clk);
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_go", 32'(ready), 32'd1);
    c[0] = v.c0; c[1] = v.c1; c[2] = v.c2; c[3] = v.c3;
    go_cyc = cyc + 1;
    dots = '0;
    for (int k = 0; k < 4; k++) begin
      r.addr = ADDR_W'(int'(v.y) * int'(IMG_W) + int'(c[k]));
      r.cyc  = go_cyc + k;
      rd_q.push_back(r);
      dots[k*23 +: 23] = {15'b0, romv(int'(r.addr))};
    end
    t.dots = dots;
    t.mul  = v.emul;
    t.div  = v.ediv;
    t.res  = v.res;
    t.cyc  = go_cyc + 5;
    tx_q.push_back(t);
    src_x = v.x; src_y = v.y; frac_mul = v.mul; frac_div = v.div;
    res_val = v.res;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((px_q.size() != 0 || tx_q.size() != 0 || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("request_complete", 32'(n < 200), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_dc_start"}, 32'(dc_start), 32'd0);
    chk({tag, "_dots_or"}, 32'(dc_dot0 | dc_dot1 | dc_dot2 | dc_dot3), 32'd0);
    chk({tag, "_dc_mul"}, 32'(dc_mul), 32'd0);
    chk({tag, "_dc_div"}, 32'(dc_div), 32'd1);
    chk({tag, "_pix_out"}, 32'(pix_out), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = '{7'd10,  7'd3,  6'd1,  6'd2,  8'hA5, 6'd1,  6'd2,  7'd9,  7'd10, 7'd11, 7'd12};
    vecs[1] = '{7'd0,   7'd3,  6'd3,  6'd7,  8'h3C, 6'd3,  6'd7,  7'd0,  7'd0,  7'd1,  7'd2};
    vecs[2] = '{7'd98,  7'd5,  6'd2,  6'd2,  8'h7E, 6'd2,  6'd2,  7'd97, 7'd98, 7'd99, 7'd99};
    vecs[3] = '{7'd99,  7'd99, 6'd0,  6'd3,  8'h01, 6'd0,  6'd3,  7'd98, 7'd99, 7'd99, 7'd99};
    vecs[4] = '{7'd50,  7'd0,  6'd5,  6'd0,  8'hFF, 6'd0,  6'd1,  7'd49, 7'd50, 7'd51, 7'd52};
    vecs[5] = '{7'd1,   7'd10, 6'd9,  6'd4,  8'h5A, 6'd4,  6'd4,  7'd0,  7'd1,  7'd2,  7'd3};
    vecs[6] = '{7'd127, 7'd2,  6'd63, 6'd63, 8'h80, 6'd63, 6'd63, 7'd99, 7'd99, 7'd99, 7'd99};

    rst = 1'b1; go = 1'b0; force_fin = 1'b0; res_val = 8'h33;
    src_x = '0; src_y = '0; frac_mul = '0; frac_div = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");

    // Spurious finish while idle.
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    chk("idle_finish_pix_valid", 32'(pix_valid), 32'd0);
    @(negedge clk);
    chk("idle_finish_ready", 32'(ready), 32'd1);
    chk("idle_finish_pix_out", 32'(pix_out), 32'd0);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i]);
      wait_idle();
    end
    chk("pix_out_hold", 32'(pix_out), 32'h80);

    // Spurious finish during READ must not disturb the request.
    issue(vecs[0]);
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    chk("read_finish_pix_valid", 32'(pix_valid), 32'd0);
    wait_idle();

    // go during WAIT is ignored.
    issue(vecs[1]);
    repeat (7) @(negedge clk);
    chk("wait_ready_low", 32'(ready), 32'd0);
    src_x = 7'd40; src_y = 7'd7; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("no_queued_read", 32'(rd_q.size()), 32'd0);

    // Reset during WAIT, then a fresh request.
    issue(vecs[2]);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("wait_rst");
    rd_q.delete(); tx_q.delete(); px_q.delete();
    rst = 1'b0;
    issue(vecs[3]);
    wait_idle();
    chk("after_rst_pix_out", 32'(pix_out), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
